top_clk_v4: RTL and testbench

//   Real-time clock keeping hours:minutes:seconds in 24-hour binary format.
//   A prescaler divides the system clock down to a 1 Hz tick, which drives cascaded mod-60/mod-60/mod-24 counters.
//   Any single time field can be preset through an address/data load port.

---
 rtl/top_clk_v4_pkg.sv | 34 +++
 rtl/top_clk_v4_mod_n_counter.sv | 36 +++
 rtl/top_clk_v4.sv | 101 ++++++++++
 tb/tb_top_clk_v4.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/top_clk_v4_pkg.sv
// Shared constants and helpers for the hh:mm:ss real-time clock.
// Field limits, field address codes, widths and a load range check.
package top_clk_v4_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam logic [1:0] ADDR_SEC = 2'b00;
  localparam logic [1:0] ADDR_MIN = 2'b01;
  localparam logic [1:0] ADDR_HR  = 2'b10;

  // True when data is a legal value for the addressed field.
  // The reserved address never qualifies.
  function automatic logic load_ok(
    input logic [1:0] addr,
    input logic [5:0] data
  );
    logic ok;
    ok = 1'b0;
    case (addr)
      ADDR_SEC: ok = (data <= 6'(SEC_MAX));
      ADDR_MIN: ok = (data <= 6'(MIN_MAX));
      ADDR_HR:  ok = (data <= 6'(HR_MAX));
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/top_clk_v4_mod_n_counter.sv
// Loadable modulo-N counter with ripple carry output.
// Ports: clk, reset, inc, load_en, load_val[W-1:0], out[W-1:0], carry.
module mod_n_counter #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] out,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic at_last;

  assign at_last = (out == LAST);

  // Carry fires in the cycle this stage wraps, so the
  // next stage advances on the same edge.
  assign carry = inc && at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (load_en) begin
      out <= load_val;
    end else if (inc) begin
      out <= at_last ? '0 : out + 1'b1;
    end
  end

endmodule

// File: rtl/top_clk_v4.sv
// 24-hour binary real-time clock: prescaler to 1 Hz tick,
// cascaded mod-60/60/24 counters, per-field preset port.
// Ports: clk, reset, load, addrs[1:0], data_in[5:0],
//        seconds_out[5:0], minutes_out[5:0], hours_out[4:0].
module top_clk_v4
  import top_clk_v4_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [1:0]       addrs,
  input  logic [5:0]       data_in,
  output logic [SEC_W-1:0] seconds_out,
  output logic [MIN_W-1:0] minutes_out,
  output logic [HR_W-1:0]  hours_out
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          vload;
  logic          ld_sec;
  logic          ld_min;
  logic          ld_hr;
  logic          inc_sec;
  logic          c_sec;
  logic          c_min;
  logic          c_hr;

  assign tick  = (pcnt == P_LAST);
  assign vload = load && load_ok(addrs, data_in);

  assign ld_sec = vload && (addrs == ADDR_SEC);
  assign ld_min = vload && (addrs == ADDR_MIN);
  assign ld_hr  = vload && (addrs == ADDR_HR);

  // A valid load freezes every field for that edge,
  // even the ones it does not address.
  assign inc_sec = tick && !vload;

  // A valid load restarts the second so the next
  // increment is a full TICK_DIV edges away.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (vload || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  mod_n_counter #(
    .N(SEC_MAX + 1),
    .W(SEC_W)
  ) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc_sec),
    .load_en  (ld_sec),
    .load_val (data_in),
    .out      (seconds_out),
    .carry    (c_sec)
  );

  mod_n_counter #(
    .N(MIN_MAX + 1),
    .W(MIN_W)
  ) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (c_sec),
    .load_en  (ld_min),
    .load_val (data_in),
    .out      (minutes_out),
    .carry    (c_min)
  );

  mod_n_counter #(
    .N(HR_MAX + 1),
    .W(HR_W)
  ) u_hr (
    .clk      (clk),
    .reset    (reset),
    .inc      (c_min),
    .load_en  (ld_hr),
    .load_val (data_in[4:0]),
    .out      (hours_out),
    .carry    (c_hr)
  );

  // Hours wrap silently; the day carry has no consumer.
  logic unused_day;
  assign unused_day = c_hr;

endmodule

// File: tb/tb_top_clk_v4.sv
// Scoreboard bench for top_clk_v4 with TICK_DIV=10.
// Stimulus queues expected times; a monitor compares them.
module tb_top_clk_v4;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic [5:0] seconds_out;
  logic [5:0] minutes_out;
  logic [4:0] hours_out;

  hms_t  exp_q[$];
  string tag_q[$];
  int    n_vec;
  int    n_bad;

  top_clk_v4 #(
    .TICK_DIV(10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .addrs       (addrs),
    .data_in     (data_in),
    .seconds_out (seconds_out),
    .minutes_out (minutes_out),
    .hours_out   (hours_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are registered, so they are stable at
  // the falling edge; every queued expectation is due there.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      hms_t  e;
      hms_t  a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '{hours_out, minutes_out, seconds_out};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %0d:%0d:%0d want %0d:%0d:%0d",
          t, a.h, a.m, a.s, e.h, e.m, e.s);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string t,
    input int h,
    input int m,
    input int s
  );
    hms_t e;
    e = '{5'(h), 6'(m), 6'(s)};
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic ld(input logic [1:0] a, input int d);
    load    = 1'b1;
    addrs   = a;
    data_in = 6'(d);
    step(1);
    load    = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    load    = 1'b0;
    addrs   = 2'b00;
    data_in = 6'd0;

    // 1: reset and free run
    step(10);
    reset = 1'b0;
    chk("reset", 0, 0, 0);
    step(9);
    chk("pre_tick1", 0, 0, 0);
    step(1);
    chk("tick1", 0, 0, 1);
    step(10);
    chk("tick2", 0, 0, 2);

    // 2: hour preset restarts the second
    ld(2'b10, 17);
    chk("ld_hr17", 17, 0, 2);
    step(9);
    chk("ld_hr_hold", 17, 0, 2);
    step(1);
    chk("ld_hr_tick", 17, 0, 3);

    // 3: full wrap and minute->hour carry
    ld(2'b00, 59);
    ld(2'b01, 59);
    ld(2'b10, 23);
    chk("ld_235959", 23, 59, 59);
    step(9);
    chk("pre_midnight", 23, 59, 59);
    step(1);
    chk("midnight", 0, 0, 0);
    ld(2'b10, 5);
    ld(2'b01, 59);
    ld(2'b00, 59);
    chk("ld_055959", 5, 59, 59);
    step(10);
    chk("hr_carry", 6, 0, 0);

    // 4: rejected loads, prescaler keeps running
    ld(2'b00, 60);
    ld(2'b10, 24);
    ld(2'b11, 5);
    ld(2'b01, 63);
    chk("bad_loads", 6, 0, 0);
    step(5);
    chk("bad_pre", 6, 0, 0);
    step(1);
    chk("bad_tick", 6, 0, 1);

    // 5: reset mid-count
    ld(2'b10, 12);
    ld(2'b01, 34);
    ld(2'b00, 56);
    step(4);
    chk("ld_123456", 12, 34, 56);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_reset", 0, 0, 0);
    step(9);
    chk("rst_pre", 0, 0, 0);
    step(1);
    chk("rst_tick", 0, 0, 1);

    // 6: load on tick wins; reserved load on tick does not
    step(9);
    ld(2'b00, 30);
    chk("ld_on_tick", 0, 0, 30);
    step(10);
    chk("after_ld_tick", 0, 0, 31);
    step(9);
    ld(2'b11, 0);
    chk("rsv_on_tick", 0, 0, 32);

    // held load freezes time
    load    = 1'b1;
    addrs   = 2'b01;
    data_in = 6'd10;
    for (int i = 0; i < 30; i++) begin
      step(1);
      chk("held_load", 0, 10, 32);
    end
    load = 1'b0;
    step(9);
    chk("unfreeze_pre", 0, 10, 32);
    step(1);
    chk("unfreeze", 0, 10, 33);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() > 0) step(1);
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0",
        exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
